mem_bus_master: RTL and testbench

Initiator side of the 8-bit system memory bus. It takes 16-bit word load/store requests from the CPU load/store path and turns them into two byte transactions on the `memory` block's bus: address, bidirectional data, write enable and chip select. Words are big-endian: the high byte goes to address A and the low byte to A+1. It sits between the CPU's load/store unit and `memory` inside `system`.

---
 rtl/mem_bus_master.sv | 115 +++++++++++
 tb/tb_mem_bus_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: splits 16-bit big-endian word loads/stores into two byte
// cycles on the 8-bit memory bus (high byte at A, low byte at A+1).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready/write/addr/wdata   CPU word request (valid/ready)
//   resp_valid, resp_rdata        completion pulse, load result (held)
//   mem_addr, mem_data, mem_we, mem_cs  byte bus to memory (mem_data tri-state)
module mem_bus_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int READ_WAIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    output logic [15:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  mem_cs
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR_HI = 3'd1;
    localparam logic [2:0] WR_LO = 3'd2;
    localparam logic [2:0] RD_HI = 3'd3;
    localparam logic [2:0] RD_LO = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT - 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [15:0]           wdata_q;
    logic [7:0]            rdata_hi;
    logic [CW-1:0]         wait_cnt;
    logic                  wait_done;
    logic [7:0]            wr_byte;

    // Natural overflow gives the required wrap of A+1.
    assign addr_inc  = addr_q + ADDR_WIDTH'(1);
    assign wait_done = (wait_cnt == WAIT_LAST);

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == WR_HI) || (state == WR_LO);
    assign mem_cs     = mem_we || (state == RD_HI) || (state == RD_LO);
    assign wr_byte    = (state == WR_HI) ? wdata_q[15:8] : wdata_q[7:0];
    // Bus is driven only while writing, so reads never contend.
    assign mem_data   = mem_we ? wr_byte : 8'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_hi   <= '0;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        mem_addr <= req_addr;
                        wait_cnt <= '0;
                        state    <= req_write ? WR_HI : RD_HI;
                    end
                end
                WR_HI: begin
                    mem_addr <= addr_inc;
                    state    <= WR_LO;
                end
                WR_LO: begin
                    state <= RESP;
                end
                RD_HI: begin
                    if (wait_done) begin
                        rdata_hi <= mem_data;
                        wait_cnt <= '0;
                        mem_addr <= addr_inc;
                        state    <= RD_LO;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_LO: begin
                    if (wait_done) begin
                        resp_rdata <= {rdata_hi, mem_data};
                        wait_cnt   <= '0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: bench for mem_bus_master with a byte memory on the bus,
// a word-level reference model, table vectors and multi-cycle sequences.
module tb_mem_bus_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        v0 = 1'b0, w0 = 1'b0;
    logic [15:0] a0 = '0, d0 = '0;
    logic        rdy0, rv0, we0, cs0;
    logic [15:0] rd0, ma0;
    wire  [7:0]  md0;

    logic        v1 = 1'b0, w1 = 1'b0;
    logic [15:0] a1 = '0, d1 = '0;
    logic        rdy1, rv1, we1, cs1;
    logic [15:0] rd1, ma1;
    wire  [7:0]  md1;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] last_rd;

    int total = 0;
    int bad = 0;
    int viol = 0;

    mem_bus_master #(.ADDR_WIDTH(16), .READ_WAIT(1)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(rdy0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0),
        .resp_valid(rv0), .resp_rdata(rd0),
        .mem_addr(ma0), .mem_data(md0), .mem_we(we0), .mem_cs(cs0)
    );

    mem_bus_master #(.ADDR_WIDTH(16), .READ_WAIT(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1),
        .resp_valid(rv1), .resp_rdata(rd1),
        .mem_addr(ma1), .mem_data(md1), .mem_we(we1), .mem_cs(cs1)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write at the clock edge.
    assign md0 = (cs0 && !we0) ? mem0[ma0] : 8'bz;
    assign md1 = (cs1 && !we1) ? mem1[ma1] : 8'bz;

    always @(posedge clk) begin
        if (cs0 && we0) mem0[ma0] = md0;
        if (cs1 && we1) mem1[ma1] = md1;
    end

    always @(negedge clk) begin
        if (we0 && !cs0) viol++;
        if (we1 && !cs1) viol++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One word transaction on dut0. Returns the reference-model expectation,
    // the observed rdata, latency (negedges after accept) and write cycles.
    task automatic txn0(input bit w, input logic [15:0] a,
                        input logic [15:0] d,
                        output logic [15:0] mexp, output logic [15:0] rd,
                        output int lat, output int wecnt);
        int n;
        logic [15:0] an;
        an = a + 16'd1;
        mexp = w ? last_rd : {ref_mem[a], ref_mem[an]};
        lat = -1;
        wecnt = 0;
        rd = '0;
        @(negedge clk);
        v0 = 1'b1; w0 = w; a0 = a; d0 = d;
        n = 0;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) begin
            check("ready_timeout", 0, 1);
            v0 = 1'b0;
            return;
        end
        @(negedge clk);
        v0 = 1'b0;
        w0 = 1'($urandom);
        a0 = 16'($urandom);
        d0 = 16'($urandom);
        for (int k = 0; k < 20; k++) begin
            if (we0) wecnt++;
            if (rv0) begin
                lat = k;
                rd = rd0;
                break;
            end
            @(negedge clk);
        end
        if (w) begin
            ref_mem[a] = d[15:8];
            ref_mem[an] = d[7:0];
        end else begin
            last_rd = mexp;
        end
    endtask

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] mexp, rd;
        int lat, wecnt, pulses, lat2;
        logic [15:0] rd2;
        logic [3:0] rdy_seen;

        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem1[16'h0020] = 8'hBE;
        mem1[16'h0021] = 8'hEF;
        last_rd = '0;

        vecs[0] = '{1'b1, 16'h0002, 16'hA5C3, 16'h0000};
        vecs[1] = '{1'b0, 16'h0002, 16'h0000, 16'hA5C3};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h1234, 16'hA5C3};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234};
        vecs[4] = '{1'b0, 16'h0003, 16'h0000, 16'hC300};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h3400};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy0, 0);
        check("rst_resp_valid", rv0, 0);
        check("rst_rdata", rd0, 16'h0000);
        check("rst_mem_addr", ma0, 16'h0000);
        check("rst_mem_we", we0, 0);
        check("rst_mem_cs", cs0, 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            txn0(vecs[i].w, vecs[i].a, vecs[i].d, mexp, rd, lat, wecnt);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("vec%0d_lat", i), lat, 2);
            check($sformatf("vec%0d_we_cycles", i), wecnt, vecs[i].w ? 2 : 0);
        end
        check("mem_2", mem0[16'h0002], 8'hA5);
        check("mem_3", mem0[16'h0003], 8'hC3);
        check("mem_ffff", mem0[16'hFFFF], 8'h12);
        check("mem_0", mem0[16'h0000], 8'h34);

        // Back-pressure: store then load held on req_valid
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b1; a0 = 16'h0010; d0 = 16'h5A6B;
        check("bp_ready_pre", rdy0, 1);
        @(negedge clk);
        w0 = 1'b0;
        pulses = 0;
        lat2 = -1;
        rd2 = '0;
        rdy_seen = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) rdy_seen[k] = rdy0;
            if (k == 4) v0 = 1'b0;
            if (rv0) begin
                pulses++;
                if (k > 2) begin
                    lat2 = k;
                    rd2 = rd0;
                end
            end
            @(negedge clk);
        end
        check("bp_ready_busy", {29'd0, rdy_seen[2:0]}, 0);
        check("bp_ready_back", rdy_seen[3], 1);
        check("bp_pulses", pulses, 2);
        check("bp_second_resp_at", lat2, 6);
        check("bp_rdata", rd2, 16'h5A6B);
        ref_mem[16'h0010] = 8'h5A;
        ref_mem[16'h0011] = 8'h6B;
        last_rd = 16'h5A6B;

        // Reset in the middle of RD_LO
        v0 = 1'b1; w0 = 1'b0; a0 = 16'h0002;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_cs", cs0, 0);
        check("mrst_ready", rdy0, 0);
        check("mrst_resp_valid", rv0, 0);
        check("mrst_rdata", rd0, 16'h0000);
        @(negedge clk);
        check("mrst_ready_held", rdy0, 0);
        rst = 1'b0;
        last_rd = '0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (rv0) pulses++;
            @(negedge clk);
        end
        check("mrst_no_resp", pulses, 0);
        txn0(1'b0, 16'h0002, 16'h0000, mexp, rd, lat, wecnt);
        check("mrst_reload_rdata", rd, 16'hA5C3);
        check("mrst_reload_lat", lat, 2);

        // READ_WAIT=2 instance
        @(negedge clk);
        v1 = 1'b1; w1 = 1'b0; a1 = 16'h0020;
        check("rw2_ready", rdy1, 1);
        @(negedge clk);
        v1 = 1'b0;
        lat = -1;
        rd = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < 4) begin
                check($sformatf("rw2_addr%0d", k), ma1,
                      (k < 2) ? 16'h0020 : 16'h0021);
                check($sformatf("rw2_cs%0d", k), cs1, 1);
            end
            if (rv1) begin
                lat = k;
                rd = rd1;
                break;
            end
            @(negedge clk);
        end
        check("rw2_lat", lat, 4);
        check("rw2_rdata", rd, 16'hBEEF);

        // Randomised traffic against the word-level model
        for (int i = 0; i < 30; i++) begin
            bit w;
            logic [15:0] a, d;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                            : 16'hFFF0 + 16'($urandom_range(0, 15));
            d = 16'($urandom);
            txn0(w, a, d, mexp, rd, lat, wecnt);
            check($sformatf("rnd%0d_rdata", i), rd, mexp);
            check($sformatf("rnd%0d_lat", i), lat, 2);
            check($sformatf("rnd%0d_we", i), wecnt, w ? 2 : 0);
        end

        check("we_without_cs", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
